// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder.
// The master drives operands and out_ready; the slave (adder) drives the result side.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 66
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor, one SLICE of bits per stage; latency STAGES cycles.
// Rigid shift pipeline: every stage holds while the output is valid and not taken, in_ready = advance.
module pipelined_cla_adder #(
  parameter int WIDTH  = 66,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_cla_adder_if.slave io
);
  localparam int SLICE = (WIDTH + STAGES - 1) / STAGES;
  localparam int NGRP  = (SLICE + GROUP - 1) / GROUP;
  localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             vld_q [STAGES];
  logic             vld_d [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic             cm_q  [STAGES];
  logic             cm_d  [STAGES];

  logic             adv;
  logic             v_in;
  logic             c_in;
  logic             cm_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] s_in;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic             gc;
  logic             bc;
  logic             gg;
  logic             pg;
  logic [IW-1:0]    idx;
  int               km;
  int               off;
  int               pos;

  always_comb begin
    adv   = ~vld_q[STAGES-1] | io.out_ready;
    v_in  = 1'b0;
    c_in  = 1'b0;
    cm_in = 1'b0;
    a_in  = '0;
    b_in  = '0;
    s_in  = '0;
    gen   = '0;
    prop  = '0;
    gc    = 1'b0;
    bc    = 1'b0;
    gg    = 1'b0;
    pg    = 1'b0;
    idx   = '0;
    km    = 0;
    off   = 0;
    pos   = 0;
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = 1'b0;
      a_d[k]   = '0;
      b_d[k]   = '0;
      s_d[k]   = '0;
      c_d[k]   = 1'b0;
      cm_d[k]  = 1'b0;
    end

    for (int k = 0; k < STAGES; k++) begin
      km = (k > 0) ? k - 1 : 0;
      // Subtraction folds into addition here; later stages only ever add.
      if (k == 0) begin
        v_in  = io.in_valid;
        a_in  = io.a;
        b_in  = io.sub ? ~io.b : io.b;
        s_in  = '0;
        c_in  = io.sub | io.cin;
        cm_in = 1'b0;
      end else begin
        v_in  = vld_q[km];
        a_in  = a_q[km];
        b_in  = b_q[km];
        s_in  = s_q[km];
        c_in  = c_q[km];
        cm_in = cm_q[km];
      end
      gen      = a_in & b_in;
      prop     = a_in ^ b_in;
      s_d[k]   = s_in;
      cm_d[k]  = cm_in;
      gc       = c_in;

      for (int g = 0; g < NGRP; g++) begin
        gg = 1'b0;
        pg = 1'b1;
        for (int i = 0; i < GROUP; i++) begin
          off = g * GROUP + i;
          pos = k * SLICE + off;
          if (off < SLICE && pos < WIDTH) begin
            idx = IW'(pos);
            gg  = gen[idx] | (prop[idx] & gg);
            pg  = pg & prop[idx];
          end
        end
        // Bit carries inside the group start from the group carry-in.
        bc = gc;
        for (int i = 0; i < GROUP; i++) begin
          off = g * GROUP + i;
          pos = k * SLICE + off;
          if (off < SLICE && pos < WIDTH) begin
            idx = IW'(pos);
            if (pos == WIDTH - 1) begin
              cm_d[k] = bc;
            end
            s_d[k][idx] = prop[idx] ^ bc;
            bc          = gen[idx] | (prop[idx] & bc);
          end
        end
        gc = gg | (pg & gc);
      end

      vld_d[k] = v_in;
      a_d[k]   = a_in;
      b_d[k]   = b_in;
      c_d[k]   = gc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        cm_q[k]  <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
        cm_q[k]  <= cm_d[k];
      end
    end
  end

  assign io.in_ready  = adv;
  assign io.out_valid = vld_q[STAGES-1];
  assign io.sum       = s_q[STAGES-1];
  assign io.cout      = c_q[STAGES-1];
  assign io.ovf       = cm_q[STAGES-1] ^ c_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for three adder configurations (66/2 stages, 17/3 stages/GROUP 3, 66/1 stage).
// The driver pushes expected results at accept time; a negedge monitor pops and compares on output transfers.
module tb_pipelined_cla_adder;
  typedef struct packed {
    logic [65:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tb_in_valid = 1'b0;
  logic        tb_cin = 1'b0;
  logic        tb_sub = 1'b0;
  logic        tb_out_ready = 1'b1;
  logic [65:0] tb_a = '0;
  logic [65:0] tb_b = '0;
  int          sel = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  res_t        sb_q[$];
  res_t        mon_exp;

  logic        m_in_ready;
  logic        m_out_valid;
  logic [65:0] m_sum;
  logic        m_cout;
  logic        m_ovf;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_cla_adder_if #(.WIDTH(66)) if_a ();
  pipelined_cla_adder_if #(.WIDTH(17)) if_b ();
  pipelined_cla_adder_if #(.WIDTH(66)) if_c ();

  pipelined_cla_adder #(.WIDTH(66), .GROUP(4), .STAGES(2)) dut_a (.clk(clk), .rst(rst), .io(if_a.slave));
  pipelined_cla_adder #(.WIDTH(17), .GROUP(3), .STAGES(3)) dut_b (.clk(clk), .rst(rst), .io(if_b.slave));
  pipelined_cla_adder #(.WIDTH(66), .GROUP(4), .STAGES(1)) dut_c (.clk(clk), .rst(rst), .io(if_c.slave));

  assign if_a.in_valid = tb_in_valid && (sel == 0);
  assign if_a.a = tb_a;
  assign if_a.b = tb_b;
  assign if_a.cin = tb_cin;
  assign if_a.sub = tb_sub;
  assign if_a.out_ready = tb_out_ready;
  assign if_b.in_valid = tb_in_valid && (sel == 1);
  assign if_b.a = tb_a[16:0];
  assign if_b.b = tb_b[16:0];
  assign if_b.cin = tb_cin;
  assign if_b.sub = tb_sub;
  assign if_b.out_ready = tb_out_ready;
  assign if_c.in_valid = tb_in_valid && (sel == 2);
  assign if_c.a = tb_a;
  assign if_c.b = tb_b;
  assign if_c.cin = tb_cin;
  assign if_c.sub = tb_sub;
  assign if_c.out_ready = tb_out_ready;

  always_comb begin
    m_in_ready  = if_a.in_ready;
    m_out_valid = if_a.out_valid;
    m_sum       = if_a.sum;
    m_cout      = if_a.cout;
    m_ovf       = if_a.ovf;
    if (sel == 1) begin
      m_in_ready  = if_b.in_ready;
      m_out_valid = if_b.out_valid;
      m_sum       = {49'd0, if_b.sum};
      m_cout      = if_b.cout;
      m_ovf       = if_b.ovf;
    end else if (sel == 2) begin
      m_in_ready  = if_c.in_ready;
      m_out_valid = if_c.out_valid;
      m_sum       = if_c.sum;
      m_cout      = if_c.cout;
      m_ovf       = if_c.ovf;
    end
  end

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && m_out_valid && tb_out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output dut%0d: got sum=%h cout=%b ovf=%b, expected no output", sel, m_sum, m_cout, m_ovf);
      end else begin
        mon_exp = sb_q.pop_front();
        if (m_sum !== mon_exp.sum || m_cout !== mon_exp.cout || m_ovf !== mon_exp.ovf) begin
          errors++;
          $display("FAIL result dut%0d: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                   sel, m_sum, m_cout, m_ovf, mon_exp.sum, mon_exp.cout, mon_exp.ovf);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [67:0] got, input logic [67:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", name, sel, got, exp);
    end
  endtask

  function automatic res_t mk(input logic [65:0] s, input logic c, input logic o);
    res_t r;
    r.sum  = s;
    r.cout = c;
    r.ovf  = o;
    return r;
  endfunction

  function automatic logic [65:0] wmask(input int w);
    logic [66:0] t;
    t = (67'd1 << w) - 67'd1;
    return t[65:0];
  endfunction

  // Reference: plain wide addition, overflow from operand/result sign bits.
  function automatic res_t model(input logic [65:0] a, input logic [65:0] b, input logic ci,
                                 input logic su, input int w);
    logic [67:0] m;
    logic [67:0] aa;
    logic [67:0] bb;
    logic [67:0] full;
    res_t        r;
    m    = (68'd1 << w) - 68'd1;
    aa   = {2'b00, a} & m;
    bb   = su ? (~{2'b00, b} & m) : ({2'b00, b} & m);
    full = aa + bb + {67'd0, su | ci};
    r.sum  = full[65:0] & m[65:0];
    r.cout = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return r;
  endfunction

  task automatic send(input logic [65:0] a, input logic [65:0] b, input logic ci, input logic su, input res_t e);
    int t;
    t = 0;
    tb_a = a;
    tb_b = b;
    tb_cin = ci;
    tb_sub = su;
    tb_in_valid = 1'b1;
    @(negedge clk);
    while (!m_in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (m_in_ready) begin
      sb_q.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: got in_ready=0 expected 1 within 200 cycles", sel);
    end
    @(posedge clk);
    #1;
    tb_in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_outstanding", 68'(sb_q.size()), 68'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_dut(input int w, input int s);
    logic [65:0] mask;
    logic [65:0] top;
    logic [95:0] ra;
    logic [95:0] rb;
    logic        ci;
    logic        su;
    int          n;
    int          st;
    mask = wmask(w);
    top  = 66'd1 << (w - 1);

    // Carry ripples across every slice boundary; also measures latency.
    send(mask, 66'd1, 1'b0, 1'b0, mk(66'd0, 1'b1, 1'b0));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_out_valid && n < 20);
    chk("latency", 68'(n), 68'(s));
    @(posedge clk);
    #1;
    send(66'd5, 66'd7, 1'b0, 1'b1, mk(mask - 66'd1, 1'b0, 1'b0));
    send(66'd7, 66'd5, 1'b1, 1'b1, mk(66'd2, 1'b1, 1'b0));
    send(top - 66'd1, 66'd1, 1'b0, 1'b0, mk(top, 1'b0, 1'b1));
    send(top, top, 1'b0, 1'b0, mk(66'd0, 1'b1, 1'b1));
    send(66'd10, 66'd20, 1'b1, 1'b0, mk(66'd31, 1'b0, 1'b0));
    send(66'd9, 66'd9, 1'b0, 1'b1, mk(66'd0, 1'b1, 1'b0));
    drain();

    st = cyc;
    for (int i = 0; i < 100; i++) begin
      ra = {$urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom()};
      ci = 1'($urandom_range(0, 1));
      su = 1'($urandom_range(0, 1));
      send(ra[65:0] & mask, rb[65:0] & mask, ci, su, model(ra[65:0], rb[65:0], ci, su, w));
    end
    chk("stream_cycles", 68'(cyc - st), 68'd100);
    drain();

    tb_out_ready = 1'b0;
    for (int i = 0; i < s; i++) begin
      ra = {$urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom()};
      send(ra[65:0] & mask, rb[65:0] & mask, 1'b1, 1'b0, model(ra[65:0], rb[65:0], 1'b1, 1'b0, w));
    end
    tb_a = 66'd3 & mask;
    tb_b = 66'd4 & mask;
    tb_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {67'd0, m_in_ready}, 68'd0);
      chk("stall_out_valid", {67'd0, m_out_valid}, 68'd1);
      chk("stall_result", {m_sum, m_cout, m_ovf}, {sb_q[0].sum, sb_q[0].cout, sb_q[0].ovf});
      @(posedge clk);
      #1;
    end
    tb_out_ready = 1'b1;
    send(66'd3, 66'd4, 1'b0, 1'b0, mk(66'd7, 1'b0, 1'b0));
    drain();
  endtask

  initial begin
    #1;
    chk("reset_out_valid", {67'd0, m_out_valid}, 68'd0);
    chk("reset_sum", {2'b00, m_sum}, 68'd0);
    chk("reset_in_ready", {67'd0, m_in_ready}, 68'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    sel = 0;
    run_dut(66, 2);
    sel = 1;
    run_dut(17, 3);
    sel = 2;
    run_dut(66, 1);

    // Two results in flight, then a one-cycle reset discards both.
    sel = 0;
    send(66'd100, 66'd1, 1'b0, 1'b0, mk(66'd101, 1'b0, 1'b0));
    send(66'd200, 66'd2, 1'b0, 1'b0, mk(66'd202, 1'b0, 1'b0));
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {67'd0, m_out_valid}, 68'd0);
    chk("midrst_sum", {2'b00, m_sum}, 68'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {67'd0, m_out_valid}, 68'd0);
    end
    @(posedge clk);
    #1;
    send(66'd1, 66'd2, 1'b0, 1'b0, mk(66'd3, 1'b0, 1'b0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
